fetch_issue: RTL and testbench

FETCH_ISSUE -- requirements
Module: fetch_issue

---
 rtl/fetch_issue_pkg.sv | 37 +++
 rtl/fetch_flags_reg.sv | 27 ++
 rtl/fetch_issue.sv | 102 ++++++++++
 tb/tb_fetch_issue.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_issue_pkg.sv
// Shared definitions for the fetch/issue front end: opcodes, field positions,
// PC width and FSM state encoding.
package fetch_issue_pkg;

    localparam int PC_W    = 16;
    localparam int OP_W    = 5;
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 27;
    localparam int TGT_MSB = 15;
    localparam int TGT_LSB = 0;

    localparam logic [OP_W-1:0] OP_CMP_R = 5'b00100;
    localparam logic [OP_W-1:0] OP_CMP_I = 5'b00101;
    localparam logic [OP_W-1:0] OP_JMP   = 5'b10011;
    localparam logic [OP_W-1:0] OP_BNE   = 5'b10100;
    localparam logic [OP_W-1:0] OP_BEQ   = 5'b10101;
    localparam logic [OP_W-1:0] OP_NOP   = 5'b10111;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    function automatic logic [OP_W-1:0] op_field(input logic [31:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [PC_W-1:0] target_field(input logic [31:0] word);
        return word[TGT_MSB:TGT_LSB];
    endfunction

    // Only compares are allowed to update the condition flags.
    function automatic logic is_compare(input logic [OP_W-1:0] op);
        return (op == OP_CMP_R) || (op == OP_CMP_I);
    endfunction

endpackage

// File: rtl/fetch_flags_reg.sv
// Two-bit condition flag register with load enable and synchronous reset.
module fetch_flags_reg
    import fetch_issue_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_en,
    input  logic [1:0] flags_d,
    output logic [1:0] flags_q
);

    logic [1:0] flags_r;

    // Flag storage: cleared on reset, loaded only when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r <= 2'b00;
        end else if (load_en) begin
            flags_r <= flags_d;
        end else begin
            flags_r <= flags_r;
        end
    end

    assign flags_q = flags_r;

endmodule

// File: rtl/fetch_issue.sv
// Two-state fetch/issue front end: fetches one word from instruction memory,
// presents it to the control unit, then picks the next PC.
module fetch_issue
    import fetch_issue_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        MuxDireccionPC,
    input  logic [1:0]  alu_flags,
    output logic [4:0]  Opcode,
    output logic [1:0]  Flags,
    output logic        instr_valid,
    output logic [31:0] instr_word
);

    state_t            state_r;
    logic [PC_W-1:0]   pc_r;
    logic [31:0]       ir_r;
    logic              imem_req_r;
    logic              instr_valid_r;
    logic [OP_W-1:0]   opcode_r;
    logic [PC_W-1:0]   pc_next_s;
    logic              flags_load_s;

    // Next PC candidate and flag-load decision for the current issue slot.
    always_comb begin
        pc_next_s    = pc_r + 16'd1;
        flags_load_s = 1'b0;
        if (MuxDireccionPC) begin
            pc_next_s = target_field(ir_r);
        end else begin
            pc_next_s = pc_r + 16'd1;
        end
        if ((state_r == ST_ISSUE) && !stall) begin
            flags_load_s = is_compare(op_field(ir_r));
        end else begin
            flags_load_s = 1'b0;
        end
    end

    // Fetch/issue FSM; outputs are registered together with the state so
    // they always match the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_FETCH;
            pc_r          <= 16'h0000;
            ir_r          <= 32'h0000_0000;
            imem_req_r    <= 1'b1;
            instr_valid_r <= 1'b0;
            opcode_r      <= OP_NOP;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem_ack) begin
                        state_r       <= ST_ISSUE;
                        ir_r          <= imem_data;
                        imem_req_r    <= 1'b0;
                        instr_valid_r <= 1'b1;
                        opcode_r      <= op_field(imem_data);
                    end
                end
                ST_ISSUE: begin
                    if (!stall) begin
                        state_r       <= ST_FETCH;
                        pc_r          <= pc_next_s;
                        imem_req_r    <= 1'b1;
                        instr_valid_r <= 1'b0;
                        opcode_r      <= OP_NOP;
                    end
                end
                default: begin
                    state_r       <= ST_FETCH;
                    imem_req_r    <= 1'b1;
                    instr_valid_r <= 1'b0;
                    opcode_r      <= OP_NOP;
                end
            endcase
        end
    end

    // Flags captured here are only visible from the following cycle, so a
    // compare cannot steer a branch in its own issue slot.
    fetch_flags_reg u_flags (
        .clk     (clk),
        .reset   (reset),
        .load_en (flags_load_s),
        .flags_d (alu_flags),
        .flags_q (Flags)
    );

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign instr_valid = instr_valid_r;
    assign Opcode      = opcode_r;
    assign instr_word  = ir_r;

endmodule

// File: tb/tb_fetch_issue.sv
// Scoreboard bench for fetch_issue: expected fetch addresses are queued when
// the issue controls are driven and popped when the DUT next requests memory.
module tb_fetch_issue;

    localparam logic [4:0] NOP = 5'b10111;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        stall;
    logic        MuxDireccionPC;
    logic [1:0]  alu_flags;
    logic [4:0]  Opcode;
    logic [1:0]  Flags;
    logic        instr_valid;
    logic [31:0] instr_word;

    int          total = 0;
    int          bad = 0;
    logic [15:0] addr_q[$];
    logic [15:0] mpc;
    logic [1:0]  mflags;
    logic [31:0] cur_ir;

    always #5 clk = ~clk;

    fetch_issue dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_data      (imem_data),
        .stall          (stall),
        .MuxDireccionPC (MuxDireccionPC),
        .alu_flags      (alu_flags),
        .Opcode         (Opcode),
        .Flags          (Flags),
        .instr_valid    (instr_valid),
        .instr_word     (instr_word)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ack_in, input logic stall_in);
        reset     = 1'b1;
        imem_ack  = ack_in;
        stall     = stall_in;
        imem_data = 32'hFFFF_FFFF;
        step;
        reset    = 1'b0;
        imem_ack = 1'b0;
        stall    = 1'b0;
        chk("rst_req",   {31'd0, imem_req}, 32'd1);
        chk("rst_addr",  {16'd0, imem_addr}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_op",    {27'd0, Opcode}, {27'd0, NOP});
        chk("rst_word",  instr_word, 32'd0);
        chk("rst_flags", {30'd0, Flags}, 32'd0);
        addr_q.delete();
        addr_q.push_back(16'h0000);
        mpc    = 16'h0000;
        mflags = 2'b00;
    endtask

    task automatic fetch_instr(input logic [31:0] word, input int delay);
        logic [15:0] exp_a;
        if (addr_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
            exp_a = mpc;
        end else begin
            exp_a = addr_q.pop_front();
        end
        for (int i = 0; i <= delay; i++) begin
            chk("fetch_req",   {31'd0, imem_req}, 32'd1);
            chk("fetch_addr",  {16'd0, imem_addr}, {16'd0, exp_a});
            chk("fetch_op",    {27'd0, Opcode}, {27'd0, NOP});
            chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
            chk("fetch_flags", {30'd0, Flags}, {30'd0, mflags});
            imem_ack  = (i == delay);
            imem_data = word;
            step;
        end
        imem_ack = 1'b0;
        cur_ir   = word;
        chk("issue_valid", {31'd0, instr_valid}, 32'd1);
        chk("issue_op",    {27'd0, Opcode}, {27'd0, word[31:27]});
        chk("issue_word",  instr_word, word);
        chk("issue_req",   {31'd0, imem_req}, 32'd0);
    endtask

    task automatic issue(input int stalls, input logic mux, input logic [1:0] af);
        logic [4:0] op;
        op        = cur_ir[31:27];
        imem_ack  = 1'b1;
        imem_data = 32'hDEAD_BEEF;
        for (int i = 0; i < stalls; i++) begin
            stall          = 1'b1;
            MuxDireccionPC = ~mux;
            alu_flags      = ~af;
            step;
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_word",  instr_word, cur_ir);
            chk("stall_op",    {27'd0, Opcode}, {27'd0, op});
            chk("stall_req",   {31'd0, imem_req}, 32'd0);
            chk("stall_addr",  {16'd0, imem_addr}, {16'd0, mpc});
            chk("stall_flags", {30'd0, Flags}, {30'd0, mflags});
        end
        stall          = 1'b0;
        MuxDireccionPC = mux;
        alu_flags      = af;
        step;
        imem_ack       = 1'b0;
        MuxDireccionPC = 1'b0;
        if (op == 5'b00100 || op == 5'b00101) mflags = af;
        mpc = mux ? cur_ir[15:0] : mpc + 16'd1;
        addr_q.push_back(mpc);
    endtask

    initial begin
        imem_ack = 1'b0; imem_data = 32'd0; stall = 1'b0;
        MuxDireccionPC = 1'b0; alu_flags = 2'b00; cur_ir = 32'd0;
        do_reset(1'b0, 1'b0);

        // sequential fetch at 0..4, then a late ack at PC 5
        for (int i = 0; i < 5; i++) begin
            fetch_instr(32'h0000_0100 + i, 0);
            issue(0, 1'b0, 2'b11);
        end
        fetch_instr(32'h0000_1234, 3);
        issue(0, 1'b0, 2'b00);

        // jump taken, then not taken
        fetch_instr(32'h9800_0040, 0);
        issue(0, 1'b1, 2'b00);
        fetch_instr(32'h9800_0040, 0);
        issue(0, 1'b0, 2'b00);

        // compare loads flags; a later branch does not
        fetch_instr(32'h2000_0000, 0);
        issue(2, 1'b0, 2'b01);
        fetch_instr(32'hA800_0010, 0);
        issue(1, 1'b1, 2'b10);
        fetch_instr(32'h2800_0000, 0);
        issue(0, 1'b0, 2'b11);

        // PC wrap at 16'hFFFF after a long stall
        fetch_instr(32'h9800_FFFF, 0);
        issue(0, 1'b1, 2'b00);
        fetch_instr(32'h0000_0000, 1);
        issue(4, 1'b0, 2'b00);

        // reset in the middle of a pending fetch, with ack and stall asserted
        for (int i = 0; i < 2; i++) begin
            chk("pre_rst_req",  {31'd0, imem_req}, 32'd1);
            chk("pre_rst_addr", {16'd0, imem_addr}, 32'd0);
            step;
        end
        do_reset(1'b1, 1'b1);
        fetch_instr(32'h0800_0007, 0);
        issue(0, 1'b0, 2'b00);

        // reset while stalled in issue
        fetch_instr(32'h1111_1111, 0);
        do_reset(1'b1, 1'b1);
        fetch_instr(32'h0000_0002, 0);
        issue(0, 1'b0, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
